mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch (IF) requester and the data-access (MEM stage) requester of the pipelined processor.
- Each cycle it grants at most one request and drives the memory command.
- It tracks outstanding reads and routes each read response back to its owner.
- It emits per-requester stall signals that the hazard logic uses to freeze the PC and pipeline registers.

Parameters:
- ADDR_W, 32, byte-address width passed to memory.
- DATA_W, 32, data word width.
- MEM_LATENCY, 1, cycles from command to mem_rdata_i valid; legal 1..4.
- STARVE_LIMIT, 4, consecutive fetch losses after which fetch wins; legal 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch command accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DATA_W  fetch read data.
- if_stall_o  out  1  if_req_i & ~if_gnt_o.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  write data.
- d_gnt_o  out  1  data command accepted this cycle.
- d_rvalid_o  out  1  data read data valid.
- d_rdata_o  out  DATA_W  data read data.
- d_stall_o  out  1  d_req_i & ~d_gnt_o.
- mem_en_o  out  1  memory command strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LATENCY cycles after command.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clear the tag pipe and starve_cnt.
  - Force all gnt, rvalid, stall, mem_en and mem_we outputs to 0.
  - Force mem_addr_o and mem_wdata_o to 0.
  - Read responses in flight are dropped: no rvalid after reset releases.
- Arbitration (combinational, same cycle):
  - d_req only: grant data.
  - if_req only: grant fetch.
  - Both requesting: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - Neither requesting: no grant, mem_en_o=0, mem_addr_o=0, mem_wdata_o=0.
- Command:
  - On a grant, mem_en_o=1 and mem_addr_o is the winner's address in the same cycle.
  - Data write: mem_we_o=1, mem_wdata_o=d_wdata_i.
  - Fetch or data read: mem_we_o=0, mem_wdata_o=0.
- Throughput: one command per cycle, fully pipelined. Back-to-back grants are allowed regardless of outstanding reads.
- Tag pipe:
  - MEM_LATENCY-deep shift register of {valid, owner}.
  - A read grant pushes {1, owner}; a write or idle cycle pushes {0, x}.
  - Tail entry valid with owner=IF: if_rvalid_o=1.
  - Tail entry valid with owner=D: d_rvalid_o=1.
  - if_rdata_o and d_rdata_o both equal mem_rdata_i at all times; consumers qualify with rvalid.
- Writes complete at grant and produce no rvalid.
- Read latency: grant in cycle N gives rvalid in cycle N+MEM_LATENCY.
- Responses return in issue order. At most one rvalid is high per cycle.
- starve_cnt (4 bits, registered):
  - +1 when if_req_i & d_req_i & d_gnt_o.
  - Cleared when if_gnt_o=1 or if_req_i=0.
  - Saturates at STARVE_LIMIT.
- Requester rule: hold address/data stable while stalled.
  - The arbiter stores no request state.
  - A request dropped before grant simply is not issued.
- Simultaneous events: a grant and an rvalid in the same cycle is normal. A new grant never blocks a returning response.
- Stall outputs are combinational, with no registered delay.

Decomposition:
- Shared package:
  - Owner encoding OWNER_IF=1'b0, OWNER_D=1'b1.
  - Legal ranges for MEM_LATENCY and STARVE_LIMIT.
  - Starve counter width constant (4).
- One sub-module: mem_arbiter_tag_pipe.
  - Parameterised depth MEM_LATENCY, entries {valid, owner}.
  - Same clk/active-low async reset.
- Arbitration logic and starve counter stay in the top module.

Test Plan:
- Fetch only: if_req_i=1 at 0x0040_0000 (MEM_LATENCY=1) -> if_gnt_o=1, mem_en_o=1, mem_addr_o=0x0040_0000 same cycle; if_rvalid_o=1 next cycle with if_rdata_o=mem_rdata_i; d_* outputs stay 0.
- Collision: both req, d_we_i=0, d_addr_i=0x1001_0000 -> d_gnt_o=1, if_stall_o=1, mem_addr_o=0x1001_0000; next cycle d_rvalid_o=1, if_rvalid_o=0.
- Starvation (STARVE_LIMIT=4): both req held 6 cycles -> d granted cycles 0-3, fetch granted cycle 4, starve_cnt back to 0, d granted cycle 5.
- Write: d_req_i=1, d_we_i=1, addr 0x1001_0004, wdata 0xDEAD_BEEF -> mem_we_o=1, mem_wdata_o=0xDEAD_BEEF; no d_rvalid_o in any later cycle.
- Pipelined ordering (MEM_LATENCY=3): grants IF, D-read, IF in cycles 0,1,2 -> if_rvalid_o cycle 3, d_rvalid_o cycle 4, if_rvalid_o cycle 5, never two rvalids in one cycle.
- Reset mid-flight (MEM_LATENCY=3): read granted cycle 0, reset low cycle 1 and released cycle 2 -> outputs 0 during reset; no rvalid in cycles 2-5; starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM-stage memory port arbiter.
// Owner encoding, legal parameter ranges and the tag-pipe entry layout live here.
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int MEM_LATENCY_MIN  = 1;
  localparam int MEM_LATENCY_MAX  = 4;
  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 15;
  localparam int STARVE_CNT_W     = 4;

  function automatic tag_t make_tag(input logic valid, input owner_e owner);
    tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// MEM_LATENCY-deep shift register of {valid, owner}; the tail entry lines up
// with the cycle in which the memory presents read data for that command.
module mem_arbiter_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t i_push,
  output tag_t o_tail
);

  tag_t [MEM_LATENCY-1:0] r_pipe;

  generate
    if (MEM_LATENCY == 1) begin : g_single
      // single-stage holder for latency 1
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_push;
        end
      end
    end else begin : g_multi
      // shift towards the tail, newest entry at index 0
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= {r_pipe[MEM_LATENCY-2:0], i_push};
        end
      end
    end
  endgenerate

  assign o_tail = r_pipe[MEM_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins collisions unless fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] LP_STARVE_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] LP_CNT_ONE      = STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic [STARVE_CNT_W-1:0] w_starve_nxt;
  logic                    w_if_gnt;
  logic                    w_d_gnt;
  tag_t                    w_push;
  tag_t                    w_tail;

  // grant selection; everything is held quiet while reset is asserted
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (reset) begin
      if (d_req_i && (!if_req_i || (r_starve_cnt != LP_STARVE_LIMIT))) begin
        w_d_gnt = 1'b1;
      end else if (if_req_i) begin
        w_if_gnt = 1'b1;
      end else begin
        w_d_gnt = 1'b0;
      end
    end else begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end
  end

  // memory command for the winner
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_d_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_we_i ? d_wdata_i : '0;
    end else if (w_if_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end else begin
      mem_en_o = 1'b0;
    end
  end

  // fetch loss counter, saturating at the limit
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!if_req_i || w_if_gnt) begin
      w_starve_nxt = '0;
    end else if (w_d_gnt && (r_starve_cnt != LP_STARVE_LIMIT)) begin
      w_starve_nxt = r_starve_cnt + LP_CNT_ONE;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // starve counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign w_push = make_tag(w_if_gnt | (w_d_gnt & ~d_we_i), w_d_gnt ? OWNER_D : OWNER_IF);

  mem_arbiter_tag_pipe #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_push(w_push),
    .o_tail(w_tail)
  );

  assign if_gnt_o    = w_if_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign if_stall_o  = reset & if_req_i & ~w_if_gnt;
  assign d_stall_o   = reset & d_req_i & ~w_d_gnt;
  assign if_rvalid_o = reset & w_tail.valid & (w_tail.owner == OWNER_IF);
  assign d_rvalid_o  = reset & w_tail.valid & (w_tail.owner == OWNER_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule
